booth_seq_mult_io: RTL and testbench

//   Pin-level responder for the tile harness: operands arrive on ui_in/uio_in, a radix-2

---
 rtl/booth_pkg.sv | 12 +
 rtl/booth_step.sv | 22 ++
 rtl/booth_seq_mult_io.sv | 84 ++++++++
 tb/tb_booth_seq_mult_io.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// booth_pkg: shared state encoding, widths and pin bit indices for the Booth multiplier tile
package booth_pkg;
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   localparam int W = 8;
   localparam logic [7:0] UIO_OE = 8'hF0;
   localparam int LOAD_A_BIT = 0;
   localparam int START_BIT = 1;
   localparam int SEL_BIT = 2;
   localparam int BUSY_BIT = 4;
   localparam int DONE_BIT = 5;
   localparam int SIGN_BIT = 6;
endpackage

// File: rtl/booth_step.sv
// booth_step: one radix-2 Booth iteration (add/subtract A, then arithmetic shift right)
module booth_step #(
   parameter int W = 8
) (
   input  logic [W:0]   acc,
   input  logic [W-1:0] q,
   input  logic         q_m1,
   input  logic [W-1:0] a,
   output logic [W:0]   acc_n,
   output logic [W-1:0] q_n,
   output logic         q_m1_n
);
   logic [W:0] ax;
   logic [W:0] sum;
   assign ax = {a[W-1], a};
   always_comb begin
      sum = ({q[0], q_m1} == 2'b01) ? acc + ax : ({q[0], q_m1} == 2'b10) ? acc - ax : acc;
      acc_n = {sum[W], sum[W:1]};
      q_n = {sum[0], q[W-1:1]};
      q_m1_n = q[0];
   end
endmodule

// File: rtl/booth_seq_mult_io.sv
// booth_seq_mult_io: pin-level wrapper around a sequential radix-2 Booth multiplier
// Operands load from ui_in on strobe edges; the product is read byte-wise on uo_out.
module booth_seq_mult_io
   import booth_pkg::*;
#(
   parameter int W = 8,
   parameter int CNT_W = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);
   state_t state, state_n;
   logic [W-1:0] a, q, q_s;
   logic [W:0] acc, acc_s;
   logic q_m1, q_m1_s;
   logic [CNT_W-1:0] cnt;
   logic [2*W-1:0] result;
   logic la_q, st_q, la_edge, st_edge, last;
   logic unused_ok;

   assign la_edge = uio_in[LOAD_A_BIT] & ~la_q;
   assign st_edge = uio_in[START_BIT] & ~st_q;
   assign last = cnt == CNT_W'(W - 1);
   assign unused_ok = &{1'b0, uio_in[7:3]};

   booth_step #(.W(W)) u_step (
      .acc(acc), .q(q), .q_m1(q_m1), .a(a),
      .acc_n(acc_s), .q_n(q_s), .q_m1_n(q_m1_s)
   );

   always_comb state_n = (state == CALC) ? (last ? DONE : CALC) : (st_edge ? CALC : state);

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else if (ena) state <= state_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a <= '0;
         q <= '0;
         acc <= '0;
         q_m1 <= 1'b0;
         cnt <= '0;
         result <= '0;
         la_q <= 1'b0;
         st_q <= 1'b0;
      end else if (ena) begin
         la_q <= uio_in[LOAD_A_BIT];
         st_q <= uio_in[START_BIT];
         if (state == CALC) begin
            acc <= acc_s;
            q <= q_s;
            q_m1 <= q_m1_s;
            cnt <= cnt + 1'b1;
            if (last) result <= {acc_s[W-1:0], q_s};
         end else begin
            // a simultaneous load_a and start squares the byte on ui_in
            if (la_edge) a <= ui_in;
            if (st_edge) begin
               acc <= '0;
               q <= ui_in;
               q_m1 <= 1'b0;
               cnt <= '0;
            end
         end
      end
   end

   assign uo_out = uio_in[SEL_BIT] ? result[2*W-1:W] : result[W-1:0];
   assign uio_oe = UIO_OE;

   always_comb begin
      uio_out = '0;
      uio_out[BUSY_BIT] = state == CALC;
      uio_out[DONE_BIT] = state == DONE;
      uio_out[SIGN_BIT] = result[2*W-1];
   end
endmodule

// File: tb/tb_booth_seq_mult_io.sv
// tb_booth_seq_mult_io: directed table plus corner-case sequences and a random sweep
module tb_booth_seq_mult_io;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic ena = 1'b1;
   logic [7:0] ui_in = '0;
   logic [7:0] uio_in = '0;
   logic [7:0] uo_out, uio_out, uio_oe;
   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [15:0] p;
   } vec_t;
   vec_t tbl[10];

   booth_seq_mult_io dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in),
      .uio_in(uio_in), .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic load_a(input logic [7:0] v);
      ui_in = v;
      uio_in[0] = 1'b1;
      @(negedge clk);
      uio_in[0] = 1'b0;
      @(negedge clk);
   endtask

   task automatic read_prod(output logic [15:0] p);
      uio_in[2] = 1'b0;
      #1 p[7:0] = uo_out;
      uio_in[2] = 1'b1;
      #1 p[15:8] = uo_out;
      uio_in[2] = 1'b0;
      #1;
   endtask

   // start with B, optionally dropping ena for stall_len cycles after stall_at busy cycles
   task automatic run(input logic [7:0] b, input int stall_at, input int stall_len,
                      output int busy_n, output logic [15:0] p);
      ui_in = b;
      uio_in[1] = 1'b1;
      @(negedge clk);
      uio_in[1] = 1'b0;
      busy_n = 0;
      while (uio_out[4] && busy_n < 200) begin
         busy_n++;
         if (busy_n == stall_at) ena = 1'b0;
         if (busy_n == stall_at + stall_len) ena = 1'b1;
         @(negedge clk);
      end
      ena = 1'b1;
      read_prod(p);
   endtask

   initial begin
      int n;
      logic [15:0] p;
      logic [7:0] ra, rb;
      tbl[0] = '{8'd3, 8'd5, 16'h000F};
      tbl[1] = '{8'h80, 8'h80, 16'h4000};
      tbl[2] = '{8'd127, 8'h80, 16'hC080};
      tbl[3] = '{8'hFF, 8'd1, 16'hFFFF};
      tbl[4] = '{8'd0, 8'd0, 16'h0000};
      tbl[5] = '{8'd7, 8'hFD, 16'hFFEB};
      tbl[6] = '{8'hF9, 8'hF7, 16'h003F};
      tbl[7] = '{8'd127, 8'd127, 16'h3F01};
      tbl[8] = '{8'h80, 8'd1, 16'hFF80};
      tbl[9] = '{8'd2, 8'd64, 16'h0080};

      #12;
      check("reset uo_out", {8'h0, uo_out}, 16'h0);
      check("reset uio_out", {8'h0, uio_out}, 16'h0);
      check("reset uio_oe", {8'h0, uio_oe}, 16'h00F0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 10; i++) begin
         load_a(tbl[i].a);
         run(tbl[i].b, 0, 0, n, p);
         check("tbl busy cycles", 16'(n), 16'd8);
         check("tbl product", p, tbl[i].p);
         check("tbl done", {15'h0, uio_out[5]}, 16'h1);
         check("tbl sign", {15'h0, uio_out[6]}, {15'h0, tbl[i].p[15]});
         check("tbl unused uio_out", {12'h0, uio_out[7], uio_out[3:0] & 3'b111, uio_out[3]}, 16'h0);
      end

      // reset during the 4th CALC cycle
      load_a(8'd3);
      ui_in = 8'd5;
      uio_in[1] = 1'b1;
      @(negedge clk);
      uio_in[1] = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midcalc rst uo_out", {8'h0, uo_out}, 16'h0);
      check("midcalc rst uio_out", {8'h0, uio_out}, 16'h0);
      @(negedge clk);
      rst_n = 1'b1;
      n = 0;
      repeat (12) begin
         @(negedge clk);
         if (uio_out[5] || uio_out[4]) n++;
      end
      check("no done after reset", 16'(n), 16'd0);

      // second start during CALC is ignored, then restart from DONE
      load_a(8'd3);
      ui_in = 8'd5;
      uio_in[1] = 1'b1;
      @(negedge clk);
      uio_in[1] = 1'b0;
      @(negedge clk);
      ui_in = 8'd7;
      uio_in[1] = 1'b1;
      @(negedge clk);
      uio_in[1] = 1'b0;
      n = 0;
      while (!uio_out[5] && n < 50) begin
         n++;
         @(negedge clk);
      end
      read_prod(p);
      check("start in calc ignored", p, 16'h000F);
      run(8'd7, 0, 0, n, p);
      check("restart from done", p, 16'h0015);

      // stall with ena low for 5 cycles
      load_a(8'd3);
      run(8'd5, 3, 5, n, p);
      check("stall busy cycles", 16'(n), 16'd13);
      check("stall product", p, 16'h000F);

      // strobe raised while ena low is taken when ena returns
      ena = 1'b0;
      ui_in = 8'd2;
      uio_in[1] = 1'b1;
      repeat (3) @(negedge clk);
      check("ena low holds", {15'h0, uio_out[4]}, 16'h0);
      ena = 1'b1;
      @(negedge clk);
      uio_in[1] = 1'b0;
      check("edge kept over ena low", {15'h0, uio_out[4]}, 16'h1);
      n = 0;
      while (!uio_out[5] && n < 50) begin
         n++;
         @(negedge clk);
      end
      read_prod(p);
      check("deferred start product", p, 16'h0006);

      // simultaneous load_a and start squares the operand
      ui_in = 8'hFD;
      uio_in[1:0] = 2'b11;
      @(negedge clk);
      uio_in[1:0] = 2'b00;
      n = 0;
      while (!uio_out[5] && n < 50) begin
         n++;
         @(negedge clk);
      end
      read_prod(p);
      check("square", p, 16'h0009);

      // start held high across completion must not restart
      load_a(8'd4);
      ui_in = 8'd5;
      uio_in[1] = 1'b1;
      @(negedge clk);
      n = 0;
      while (uio_out[4] && n < 50) begin
         n++;
         @(negedge clk);
      end
      repeat (3) @(negedge clk);
      check("held start no restart busy", {15'h0, uio_out[4]}, 16'h0);
      check("held start done", {15'h0, uio_out[5]}, 16'h1);
      uio_in[1] = 1'b0;
      read_prod(p);
      check("held start product", p, 16'h0014);

      for (int i = 0; i < 200; i++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         uio_in[7:3] = 5'($urandom);
         load_a(ra);
         run(rb, 0, 0, n, p);
         check("sweep product", p, 16'($signed(ra) * $signed(rb)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
